// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock through a single
// full-adder cell (b inverted, carry-in = ~bin), with valid/ready on both sides.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_bout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_release;
  logic             w_last;
  logic             w_nb;
  logic             w_sum;
  logic             w_cout;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_release = (r_state == S_DONE) && out_ready;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  // Full-adder cell with the subtrahend bit inverted.
  assign w_nb   = ~r_b_sh[0];
  assign w_sum  = r_a_sh[0] ^ w_nb ^ r_carry;
  assign w_cout = (r_a_sh[0] & w_nb) | (r_a_sh[0] & r_carry) | (w_nb & r_carry);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_SHIFT;
      S_SHIFT: if (w_last)    w_next = S_DONE;
      S_DONE:  if (w_release) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= ~bin;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_res   <= {w_sum, r_res[WIDTH-1:1]};
      r_carry <= w_cout;
      if (w_last) begin
        // Final bit: w_sum is the result MSB, w_cout the inverted borrow.
        r_bout <= ~w_cout;
        r_ovf  <= (r_a_msb != r_b_msb) && (w_sum != r_a_msb);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_res;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed vectors with literal
// expectations plus a randomized back-to-back run scored against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int   tests = 0;
  int   fails = 0;
  int   model_checks = 0;
  res_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    res_t r;
    int   u;
    int   s;
    u    = int'(ma) - int'(mb) - int'(mbin);
    s    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    r.d  = u[W-1:0];
    r.bo = (u < 0);
    r.ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    return r;
  endfunction

  // Compare process: inputs change 1 time unit after posedge, so the negedge sees the
  // values the next posedge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      check("rdy_vld_exclusive", {31'b0, in_ready & out_valid}, 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          model_checks++;
          check("model_diff", {24'b0, diff}, {24'b0, exp_q[0].d});
          check("model_bout", {31'b0, bout}, {31'b0, exp_q[0].bo});
          check("model_ovf",  {31'b0, ovf},  {31'b0, exp_q[0].ov});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, bin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
      if (!out_valid) check({name, "_in_ready_low"}, {31'b0, in_ready}, 32'd0);
    end
    if (!out_valid) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"},  {31'b0, in_ready},  32'd1);
    check({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({name, "_diff"},      {24'b0, diff},      32'd0);
    check({name, "_bout"},      {31'b0, bout},      32'd0);
    check({name, "_ovf"},       {31'b0, ovf},       32'd0);
  endtask

  // One directed operation with literal expectations and an 8-cycle latency check.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int n;
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check({name, "_accepted"}, {31'b0, in_ready}, 32'd0);
    wait_valid(name, n);
    check({name, "_latency"}, n, W);
    check({name, "_diff"}, {24'b0, diff}, {24'b0, ed});
    check({name, "_bout"}, {31'b0, bout}, {31'b0, eb});
    check({name, "_ovf"},  {31'b0, ovf},  {31'b0, eo});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_released"}, {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int           n;
    int           acc;
    int           got;
    int           last;
    logic         will_acc;
    logic [W-1:0] hd;
    logic         hb;
    logic         ho;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    run_op("sub_5_3",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("sub_3_5",    8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("sub_80_1",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("sub_0_0_b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("sub_7f_80_b1", 8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1);

    // Backpressure: result held for 5 cycles while a new request waits.
    a = 8'h44; b = 8'h45; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("bp", n);
    hd = diff; hb = bout; ho = ovf;
    check("bp_diff", {24'b0, diff}, 32'hFF);
    check("bp_bout", {31'b0, bout}, 32'd1);
    a = 8'h11; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'b0, in_ready},  32'd0);
      check("bp_hold_res", {22'b0, diff, bout, ovf}, {22'b0, hd, hb, ho});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle", {30'b0, out_valid, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_next_accepted", {31'b0, in_ready}, 32'd0);
    wait_valid("bp_next", n);
    check("bp_next_diff", {24'b0, diff}, 32'h10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of SHIFT.
    a = 8'h55; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tick();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("abort_no_valid", {31'b0, out_valid}, 32'd0);
    end
    run_op("after_reset", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Back-to-back random stream with both handshakes held high.
    out_ready = 1'b1;
    acc = 0; got = 0; last = -1;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    in_valid = 1'b1;
    model_checks = 0;
    for (int c = 0; c < 4000 && got < 256; c++) begin
      will_acc = in_valid && in_ready;
      tick();
      if (will_acc) begin
        acc++;
        if (acc == 256) in_valid = 1'b0;
        else begin
          a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        end
      end
      if (out_valid) begin
        got++;
        if (last >= 0) check("b2b_spacing", c - last, W + 2);
        last = c;
      end
    end
    tick();
    out_ready = 1'b0;
    check("b2b_results", got, 256);
    check("b2b_model_checks", model_checks, 256);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
